// File: rtl/ci_initiator.sv
// ci_initiator: CPU-side end of the custom-instruction interface.
// Takes one pipeline request at a time and broadcasts it to the ISEs with a
// one-cycle start pulse. It then waits for the OR-ed done line and returns
// the captured result, or a timeout response if nobody answers in time.
// Every output is a flop whose next value is derived from the next state.
// The ports therefore never carry combinational paths from the inputs.
module ci_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [7:0]  reqIseId,
    input  logic [31:0] reqValueA,
    input  logic [31:0] reqValueB,
    output logic        ciStart,
    output logic [7:0]  ciIseId,
    output logic [31:0] ciValueA,
    output logic [31:0] ciValueB,
    input  logic        ciDone,
    input  logic [31:0] ciResult,
    output logic        rspValid,
    output logic [31:0] rspResult,
    output logic        rspTimeout,
    output logic        busy,
    output logic        errSpurious
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        id_q, id_d;
    logic [31:0]       val_a_q, val_a_d;
    logic [31:0]       val_b_q, val_b_d;

    logic              req_ready_q, req_ready_d;
    logic              ci_start_q, ci_start_d;
    logic [7:0]        ci_ise_id_q, ci_ise_id_d;
    logic [31:0]       ci_value_a_q, ci_value_a_d;
    logic [31:0]       ci_value_b_q, ci_value_b_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_result_q, rsp_result_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic              busy_q, busy_d;
    logic              err_spurious_q, err_spurious_d;
    logic              drive_ci_s;

    // Next-state, latch/capture and registered-output computation.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        id_d           = id_q;
        val_a_d        = val_a_q;
        val_b_d        = val_b_q;
        rsp_result_d   = rsp_result_q;
        rsp_timeout_d  = 1'b0;
        err_spurious_d = err_spurious_q;

        case (state_q)
            ST_IDLE: begin
                if (reqValid) begin
                    id_d    = reqIseId;
                    val_a_d = reqValueA;
                    val_b_d = reqValueB;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
                if (ciDone) begin
                    err_spurious_d = 1'b1;
                end else begin
                    err_spurious_d = err_spurious_q;
                end
            end
            ST_ISSUE: begin
                if (ciDone) begin
                    rsp_result_d = ciResult;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d   = CNT_W'(1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A done on the last counted cycle still beats the timeout.
                if (ciDone) begin
                    rsp_result_d = ciResult;
                    state_d      = ST_RESP;
                end else if (cnt_q == CNT_MAX) begin
                    rsp_result_d  = 32'd0;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (ciDone) begin
                    err_spurious_d = 1'b1;
                end else begin
                    err_spurious_d = err_spurious_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        drive_ci_s   = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
        req_ready_d  = (state_d == ST_IDLE);
        ci_start_d   = (state_d == ST_ISSUE);
        ci_ise_id_d  = drive_ci_s ? id_d    : 8'd0;
        ci_value_a_d = drive_ci_s ? val_a_d : 32'd0;
        ci_value_b_d = drive_ci_s ? val_b_d : 32'd0;
        rsp_valid_d  = (state_d == ST_RESP);
        busy_d       = (state_d != ST_IDLE);
    end

    // State, latched request and output registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            id_q           <= 8'd0;
            val_a_q        <= 32'd0;
            val_b_q        <= 32'd0;
            req_ready_q    <= 1'b1;
            ci_start_q     <= 1'b0;
            ci_ise_id_q    <= 8'd0;
            ci_value_a_q   <= 32'd0;
            ci_value_b_q   <= 32'd0;
            rsp_valid_q    <= 1'b0;
            rsp_result_q   <= 32'd0;
            rsp_timeout_q  <= 1'b0;
            busy_q         <= 1'b0;
            err_spurious_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            id_q           <= id_d;
            val_a_q        <= val_a_d;
            val_b_q        <= val_b_d;
            req_ready_q    <= req_ready_d;
            ci_start_q     <= ci_start_d;
            ci_ise_id_q    <= ci_ise_id_d;
            ci_value_a_q   <= ci_value_a_d;
            ci_value_b_q   <= ci_value_b_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_result_q   <= rsp_result_d;
            rsp_timeout_q  <= rsp_timeout_d;
            busy_q         <= busy_d;
            err_spurious_q <= err_spurious_d;
        end
    end

    assign reqReady    = req_ready_q;
    assign ciStart     = ci_start_q;
    assign ciIseId     = ci_ise_id_q;
    assign ciValueA    = ci_value_a_q;
    assign ciValueB    = ci_value_b_q;
    assign rspValid    = rsp_valid_q;
    assign rspResult   = rsp_result_q;
    assign rspTimeout  = rsp_timeout_q;
    assign busy        = busy_q;
    assign errSpurious = err_spurious_q;

endmodule

// File: tb/tb_ci_initiator.sv
// Directed testbench for ci_initiator with TIMEOUT_CYCLES=8.
// Cycle n is the interval after the nth rising edge, counted from the accept
// cycle 0. Inputs are driven and outputs checked #1 after each edge.
module tb_ci_initiator;

    logic        clock;
    logic        reset;
    logic        reqValid;
    logic        reqReady;
    logic [7:0]  reqIseId;
    logic [31:0] reqValueA;
    logic [31:0] reqValueB;
    logic        ciStart;
    logic [7:0]  ciIseId;
    logic [31:0] ciValueA;
    logic [31:0] ciValueB;
    logic        ciDone;
    logic [31:0] ciResult;
    logic        rspValid;
    logic [31:0] rspResult;
    logic        rspTimeout;
    logic        busy;
    logic        errSpurious;

    // Responder models: a combinational adder plus a manually driven one.
    logic        comb_mode;
    logic        man_done;
    logic [31:0] man_res;
    logic        comb_done;
    logic [31:0] comb_res;

    int checks   = 0;
    int failures = 0;

    ci_initiator #(.TIMEOUT_CYCLES(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .reqValid   (reqValid),
        .reqReady   (reqReady),
        .reqIseId   (reqIseId),
        .reqValueA  (reqValueA),
        .reqValueB  (reqValueB),
        .ciStart    (ciStart),
        .ciIseId    (ciIseId),
        .ciValueA   (ciValueA),
        .ciValueB   (ciValueB),
        .ciDone     (ciDone),
        .ciResult   (ciResult),
        .rspValid   (rspValid),
        .rspResult  (rspResult),
        .rspTimeout (rspTimeout),
        .busy       (busy),
        .errSpurious(errSpurious)
    );

    // Clock generation.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Combinational responder: answers in the start cycle with A+B.
    always_comb begin
        comb_done = 1'b0;
        comb_res  = 32'd0;
        if (comb_mode && ciStart) begin
            comb_done = 1'b1;
            comb_res  = ciValueA + ciValueB;
        end
    end

    assign ciDone   = comb_done | man_done;
    assign ciResult = comb_res | man_res;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [7:0] id, input logic [31:0] a, input logic [31:0] b);
        reqValid  = 1'b1;
        reqIseId  = id;
        reqValueA = a;
        reqValueB = b;
    endtask

    initial begin
        reset     = 1'b1;
        reqValid  = 1'b0;
        reqIseId  = 8'd0;
        reqValueA = 32'd0;
        reqValueB = 32'd0;
        comb_mode = 1'b0;
        man_done  = 1'b0;
        man_res   = 32'd0;

        // Reset state.
        step();
        step();
        chk("rst_reqReady", reqReady, 32'd1);
        chk("rst_busy", busy, 32'd0);
        chk("rst_ciStart", ciStart, 32'd0);
        chk("rst_rspValid", rspValid, 32'd0);
        chk("rst_rspResult", rspResult, 32'd0);
        chk("rst_errSpurious", errSpurious, 32'd0);
        chk("rst_ciValueA", ciValueA, 32'd0);
        reset = 1'b0;
        step();

        // Combinational responder: id 5, A=0x10, B=0x22.
        comb_mode = 1'b1;
        chk("t1_ready_c0", reqReady, 32'd1);
        accept(8'h05, 32'h10, 32'h22);
        step();
        reqValid = 1'b0;
        chk("t1_ciStart_c1", ciStart, 32'd1);
        chk("t1_ciIseId_c1", ciIseId, 32'h05);
        chk("t1_ciValueA_c1", ciValueA, 32'h10);
        chk("t1_busy_c1", busy, 32'd1);
        step();
        chk("t1_rspValid_c2", rspValid, 32'd1);
        chk("t1_rspResult_c2", rspResult, 32'h32);
        chk("t1_rspTimeout_c2", rspTimeout, 32'd0);
        chk("t1_ciIseId_c2", ciIseId, 32'd0);
        step();
        chk("t1_ready_c3", reqReady, 32'd1);
        chk("t1_rspValid_c3", rspValid, 32'd0);
        chk("t1_rspHold_c3", rspResult, 32'h32);
        comb_mode = 1'b0;

        // Multi-cycle responder answering 4 cycles after start.
        accept(8'h07, 32'h111, 32'h222);
        step();
        reqValid  = 1'b0;
        reqValueA = 32'hFFFF_FFFF;
        reqValueB = 32'hEEEE_EEEE;
        chk("t2_ciStart_c1", ciStart, 32'd1);
        step();
        chk("t2_ciStart_c2", ciStart, 32'd0);
        chk("t2_ciValueA_c2", ciValueA, 32'h111);
        step();
        step();
        step();
        man_done = 1'b1;
        man_res  = 32'hDEAD_BEEF;
        chk("t2_ciValueB_c5", ciValueB, 32'h222);
        chk("t2_ciIseId_c5", ciIseId, 32'h07);
        chk("t2_rspValid_c5", rspValid, 32'd0);
        step();
        man_done = 1'b0;
        man_res  = 32'd0;
        chk("t2_rspValid_c6", rspValid, 32'd1);
        chk("t2_rspResult_c6", rspResult, 32'hDEAD_BEEF);
        chk("t2_rspTimeout_c6", rspTimeout, 32'd0);
        step();
        chk("t2_ready_c7", reqReady, 32'd1);

        // No responder: timeout response at cycle 10.
        accept(8'h09, 32'h1, 32'h2);
        step();
        reqValid = 1'b0;
        chk("t3_busy_c1", busy, 32'd1);
        for (int c = 2; c <= 9; c++) begin
            step();
            chk("t3_busy_wait", busy, 32'd1);
            chk("t3_rspValid_wait", rspValid, 32'd0);
        end
        step();
        chk("t3_rspValid_c10", rspValid, 32'd1);
        chk("t3_rspTimeout_c10", rspTimeout, 32'd1);
        chk("t3_rspResult_c10", rspResult, 32'd0);
        chk("t3_busy_c10", busy, 32'd1);
        step();
        chk("t3_busy_c11", busy, 32'd0);
        chk("t3_rspTimeout_c11", rspTimeout, 32'd0);

        // ciDone on the final counted WAIT cycle beats the timeout.
        accept(8'h0A, 32'h3, 32'h4);
        step();
        reqValid = 1'b0;
        for (int c = 2; c <= 9; c++) begin
            step();
        end
        man_done = 1'b1;
        man_res  = 32'h1234;
        chk("t4_rspValid_c9", rspValid, 32'd0);
        step();
        man_done = 1'b0;
        man_res  = 32'd0;
        chk("t4_rspValid_c10", rspValid, 32'd1);
        chk("t4_rspTimeout_c10", rspTimeout, 32'd0);
        chk("t4_rspResult_c10", rspResult, 32'h1234);
        step();

        // Back-to-back with reqValid held and req* changed during ISSUE.
        comb_mode = 1'b1;
        accept(8'h01, 32'hA1, 32'hB1);
        step();
        accept(8'h02, 32'hA2, 32'hB2);
        chk("t5_ready_c1", reqReady, 32'd0);
        chk("t5_ciIseId_c1", ciIseId, 32'h01);
        step();
        chk("t5_rspValid_c2", rspValid, 32'd1);
        chk("t5_rspResult_c2", rspResult, 32'h152);
        chk("t5_ready_c2", reqReady, 32'd0);
        step();
        chk("t5_ready_c3", reqReady, 32'd1);
        chk("t5_ciStart_c3", ciStart, 32'd0);
        step();
        reqValid = 1'b0;
        chk("t5_ciStart_c4", ciStart, 32'd1);
        chk("t5_ciIseId_c4", ciIseId, 32'h02);
        chk("t5_ciValueA_c4", ciValueA, 32'hA2);
        step();
        chk("t5_rspResult_c5", rspResult, 32'h154);
        step();
        comb_mode = 1'b0;
        chk("t5_errSpurious", errSpurious, 32'd0);

        // Reset asserted in WAIT, then a late ciDone after release.
        accept(8'h03, 32'h5, 32'h6);
        step();
        reqValid = 1'b0;
        step();
        chk("t6_busy_wait", busy, 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_busy_rst", busy, 32'd0);
        chk("t6_ready_rst", reqReady, 32'd1);
        chk("t6_ciValueA_rst", ciValueA, 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("t6_err_before", errSpurious, 32'd0);
        man_done = 1'b1;
        man_res  = 32'h55;
        step();
        man_done = 1'b0;
        man_res  = 32'd0;
        chk("t6_errSpurious", errSpurious, 32'd1);
        chk("t6_rspValid", rspValid, 32'd0);
        chk("t6_busy_after", busy, 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t6_noRsp", rspValid, 32'd0);
            chk("t6_errSticky", errSpurious, 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
